// File: rtl/sd_tile_audio_loader_if.sv
// Bundle of the SD-side, tile-RAM and audio-stream signals of the tile/audio loader.
// The loader uses the master view; the surrounding system uses the slave view.
interface sd_tile_audio_loader_if #(
  parameter int AW = 13,
  parameter int PW = 16
);
  logic          Start;
  logic          Stop;
  logic [7:0]    ByteData;
  logic          ByteValid;
  logic          SectorReq;
  logic [23:0]   SectorAddr;
  logic          SectorAck;
  logic          TileWrEn;
  logic [AW-1:0] TileWrAddr;
  logic [PW-1:0] TileWrData;
  logic [31:0]   AudioData;
  logic          AudioValid;
  logic          AudioReady;
  logic          TilesDone;
  logic          Busy;
  logic          Overflow;

  modport master (
    input  Start, Stop, ByteData, ByteValid, SectorAck, AudioReady,
    output SectorReq, SectorAddr, TileWrEn, TileWrAddr, TileWrData,
           AudioData, AudioValid, TilesDone, Busy, Overflow
  );

  modport slave (
    output Start, Stop, ByteData, ByteValid, SectorAck, AudioReady,
    input  SectorReq, SectorAddr, TileWrEn, TileWrAddr, TileWrData,
           AudioData, AudioValid, TilesDone, Busy, Overflow
  );
endinterface

// File: rtl/sd_tile_audio_loader.sv
// SD sector stream loader: tile region into pixel writes, then a looping audio
// region into 32-bit little-endian samples through a first-word-fall-through FIFO.
module sd_tile_audio_loader #(
  parameter int          TILE_COUNT        = 32,
  parameter int          TILE_W            = 16,
  parameter int          TILE_H            = 16,
  parameter int          PIX_BYTES         = 2,
  parameter int          SECTOR_BYTES      = 512,
  parameter logic [23:0] TILE_BASE_SECTOR  = 24'h000140,
  parameter logic [23:0] AUDIO_BASE_SECTOR = 24'h000800,
  parameter int          AUDIO_SECTORS     = 1024,
  parameter int          FIFO_DEPTH        = 256
) (
  input logic MasterCLK,
  input logic Reset,
  sd_tile_audio_loader_if.master bus
);
  localparam int TOTAL_PIX    = TILE_COUNT * TILE_W * TILE_H;
  localparam int AW           = $clog2(TOTAL_PIX);
  localparam int PW           = 8 * PIX_BYTES;
  localparam int TOTAL_BYTES  = TOTAL_PIX * PIX_BYTES;
  localparam int TBW          = $clog2(TOTAL_BYTES + 1);
  localparam int SBW          = $clog2(SECTOR_BYTES);
  localparam int PBW          = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam int FAW          = $clog2(FIFO_DEPTH);
  localparam int FCW          = FAW + 1;
  localparam int SECTOR_WORDS = SECTOR_BYTES / 4;
  localparam logic [23:0] AUDIO_LAST = AUDIO_BASE_SECTOR + 24'(AUDIO_SECTORS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_REQ  = 3'd1,
    T_RECV = 3'd2,
    A_WAIT = 3'd3,
    A_REQ  = 3'd4,
    A_RECV = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [SBW-1:0] byte_cnt_r;
  logic [TBW-1:0] tile_bytes_r;
  logic [PBW-1:0] pix_byte_r;
  logic [PW-1:0]  pix_r;
  logic [AW-1:0]  pix_addr_r;
  logic [23:0]    aud_r;
  logic [1:0]     aud_cnt_r;
  logic           push_r;
  logic [31:0]    push_data_r;
  logic           stop_pend_r;
  logic           sector_req_r, tile_wr_en_r, tiles_done_r, busy_r, overflow_r, audio_valid_r;
  logic [23:0]    sector_addr_r;
  logic [AW-1:0]  tile_wr_addr_r;
  logic [PW-1:0]  tile_wr_data_r;
  logic [31:0]    mem_r [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FCW-1:0] cnt_r;

  logic start_s, byte_s, sector_end_s, tile_take_s, tile_complete_s, pix_done_s;
  logic aud_take_s, pop_s, push_ok_s, room_s, audio_state_s;
  logic [PW-1:0]  pix_next_s;
  logic [FCW-1:0] occ_s, cnt_next_s;

  assign start_s       = (state_r == IDLE) && bus.Start;
  assign byte_s        = bus.ByteValid && ((state_r == T_RECV) || (state_r == A_RECV));
  assign sector_end_s  = byte_s && (byte_cnt_r == SBW'(SECTOR_BYTES - 1));
  assign tile_take_s   = byte_s && (state_r == T_RECV) && (tile_bytes_r != TBW'(TOTAL_BYTES));
  // Region is complete if already full, or this byte is the very last tile byte.
  assign tile_complete_s = (tile_bytes_r == TBW'(TOTAL_BYTES)) ||
                           (tile_take_s && (tile_bytes_r == TBW'(TOTAL_BYTES - 1)));
  assign pix_next_s    = PW'({pix_r, bus.ByteData});
  assign pix_done_s    = tile_take_s && (pix_byte_r == PBW'(PIX_BYTES - 1));
  assign aud_take_s    = byte_s && (state_r == A_RECV);
  assign audio_state_s = (state_r == A_WAIT) || (state_r == A_REQ) || (state_r == A_RECV);
  assign pop_s         = bus.AudioReady && (cnt_r != FCW'(0));
  assign push_ok_s     = push_r && ((cnt_r != FCW'(FIFO_DEPTH)) || pop_s);
  // A word still in the push register already owns a FIFO slot.
  assign occ_s         = cnt_r + FCW'(push_r);
  assign room_s        = occ_s <= FCW'(FIFO_DEPTH - SECTOR_WORDS);
  assign cnt_next_s    = cnt_r + FCW'(push_ok_s) - FCW'(pop_s);

  // Next-state logic for the load sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.Start) state_s = T_REQ; else state_s = state_r;
      T_REQ:   if (bus.SectorAck) state_s = T_RECV; else state_s = state_r;
      T_RECV: begin
        if (sector_end_s) state_s = tile_complete_s ? A_WAIT : T_REQ;
        else              state_s = state_r;
      end
      A_WAIT: begin
        if (stop_pend_r || bus.Stop) state_s = IDLE;
        else if (room_s)             state_s = A_REQ;
        else                         state_s = state_r;
      end
      A_REQ:   if (bus.SectorAck) state_s = A_RECV; else state_s = state_r;
      A_RECV:  if (sector_end_s) state_s = A_WAIT; else state_s = state_r;
      default: state_s = IDLE;
    endcase
  end

  // State register, request/busy outputs, stop latch, sector byte count and address.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state_r       <= IDLE;
      sector_req_r  <= 1'b0;
      busy_r        <= 1'b0;
      stop_pend_r   <= 1'b0;
      byte_cnt_r    <= '0;
      sector_addr_r <= TILE_BASE_SECTOR;
    end else begin
      state_r      <= state_s;
      sector_req_r <= (state_s == T_REQ) || (state_s == A_REQ);
      busy_r       <= (state_s != IDLE);
      if (state_s == IDLE)                stop_pend_r <= 1'b0;
      else if (bus.Stop && audio_state_s) stop_pend_r <= 1'b1;
      else                                stop_pend_r <= stop_pend_r;
      if (byte_s) byte_cnt_r <= sector_end_s ? '0 : byte_cnt_r + SBW'(1);
      if (start_s)
        sector_addr_r <= TILE_BASE_SECTOR;
      else if (sector_end_s && (state_r == T_RECV))
        sector_addr_r <= tile_complete_s ? AUDIO_BASE_SECTOR : sector_addr_r + 24'd1;
      else if (sector_end_s)
        sector_addr_r <= (sector_addr_r == AUDIO_LAST) ? AUDIO_BASE_SECTOR : sector_addr_r + 24'd1;
    end
  end

  // Big-endian pixel assembly and tile RAM write port.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      tile_bytes_r   <= '0;
      pix_byte_r     <= '0;
      pix_r          <= '0;
      pix_addr_r     <= '0;
      tile_wr_en_r   <= 1'b0;
      tile_wr_addr_r <= '0;
      tile_wr_data_r <= '0;
      tiles_done_r   <= 1'b0;
    end else begin
      tile_wr_en_r <= 1'b0;
      if (start_s) begin
        tile_bytes_r <= '0;
        pix_byte_r   <= '0;
        pix_addr_r   <= '0;
        tiles_done_r <= 1'b0;
      end else if (tile_take_s) begin
        tile_bytes_r <= tile_bytes_r + TBW'(1);
        pix_r        <= pix_next_s;
        if (pix_done_s) begin
          pix_byte_r     <= '0;
          tile_wr_en_r   <= 1'b1;
          tile_wr_addr_r <= pix_addr_r;
          tile_wr_data_r <= pix_next_s;
          pix_addr_r     <= pix_addr_r + AW'(1);
          if (pix_addr_r == AW'(TOTAL_PIX - 1)) tiles_done_r <= 1'b1;
        end else begin
          pix_byte_r <= pix_byte_r + PBW'(1);
        end
      end
    end
  end

  // Little-endian sample assembly, FIFO pointers and overflow flag.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      aud_r         <= '0;
      aud_cnt_r     <= 2'd0;
      push_r        <= 1'b0;
      push_data_r   <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      cnt_r         <= '0;
      audio_valid_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      push_r <= 1'b0;
      if (start_s) begin
        aud_cnt_r  <= 2'd0;
        overflow_r <= 1'b0;
      end else if (aud_take_s) begin
        aud_r     <= {bus.ByteData, aud_r[23:8]};
        aud_cnt_r <= aud_cnt_r + 2'd1;
        if (aud_cnt_r == 2'd3) begin
          push_r      <= 1'b1;
          push_data_r <= {bus.ByteData, aud_r};
        end
      end
      if (push_r && !push_ok_s) overflow_r <= 1'b1;
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + FAW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + FAW'(1);
      cnt_r         <= cnt_next_s;
      audio_valid_r <= (cnt_next_s != FCW'(0));
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge MasterCLK) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data_r;
  end

  assign bus.SectorReq  = sector_req_r;
  assign bus.SectorAddr = sector_addr_r;
  assign bus.TileWrEn   = tile_wr_en_r;
  assign bus.TileWrAddr = tile_wr_addr_r;
  assign bus.TileWrData = tile_wr_data_r;
  assign bus.AudioData  = mem_r[rd_ptr_r];
  assign bus.AudioValid = audio_valid_r;
  assign bus.TilesDone  = tiles_done_r;
  assign bus.Busy       = busy_r;
  assign bus.Overflow   = overflow_r;
endmodule
